// File: rtl/nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder
//
// Sequential WIDTH-bit adder/subtractor built around one 4-bit adder slice.
// An operand pair is captured on a valid/ready input handshake. The slice then
// processes one nibble per cycle, LSB nibble first, with the carry held in a
// flop between cycles. The assembled result is offered with carry and signed
// overflow on a valid/ready output handshake. This trades latency
// (WIDTH/4 cycles) for a narrow adder in wide datapaths.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of 4 and >= 4
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair and mode are valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   a, b       operands (two's complement or unsigned)
//   carry_in   carry into nibble 0 for add; ignored for sub
//   sub        0: a + b + carry_in, 1: a - b computed as a + ~b + 1
//   out_valid  result is valid (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        result
//   carry_out  carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   overflow   signed overflow of the operation
//   busy       high whenever the block is not IDLE
// ----------------------------------------------------------------------------

// 4-bit adder slice: {cout, sum} = a + b + cin.
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    // A one-nibble datapath still needs a 1-bit counter to stay legal.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;     // carry between nibbles
    logic [WIDTH-1:0] op_a;      // shifts right 4 bits per RUN cycle
    logic [WIDTH-1:0] op_b;      // already inverted for sub
    logic             sa;        // sign of A
    logic             sb;        // sign of the effective B (~b for sub)

    logic [3:0]       slice_sum;
    logic             slice_cout;

    nibble_adder u_slice (
        .a    (op_a[3:0]),
        .b    (op_b[3:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Handshake flags are decoded straight from the state register, so they
    // are glitch-free and change only on clock edges (or reset).
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the result registers are reset along with the control
            // state because they are visible outputs with defined reset
            // values; operand registers are reset only to keep the whole
            // block in a known state.
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all updates see the
            // pre-edge values; a blocking = would let later statements
            // observe half-updated state and break the nibble pipeline.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        // Subtraction is a + ~b + 1, so the +1 enters as the
                        // initial carry and carry_in is ignored.
                        carry <= sub | carry_in;
                        sa    <= a[WIDTH-1];
                        sb    <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        idx   <= '0;
                        state <= RUN;
                    end
                end

                RUN: begin
                    // Nibble idx of the result comes from the slice this cycle.
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[4*i +: 4] <= slice_sum;
                        end
                    end
                    carry <= slice_cout;
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        carry_out <= slice_cout;
                        // Signed overflow: both operands share a sign and the
                        // result's sign (final slice MSB) differs from it.
                        overflow  <= (sa == sb) && (slice_sum[3] != sa);
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder (WIDTH = 16). A behavioural
// model computes each expected result from integer arithmetic; a negedge
// monitor queues a model result on every accept and compares the DUT outputs
// against the queue head on every cycle out_valid is high. Directed sequences
// pin the model and cover latency, backpressure and asynchronous reset;
// a randomized phase runs 1000+ operations with random output stalls.
// ----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;
    localparam longint MAX_S = (longint'(1) << (WIDTH - 1)) - 1;
    localparam longint MIN_S = -(longint'(1) << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             carry_in = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic msub, input logic mcin);
        res_t            r;
        longint unsigned ua, ub, ci, t;
        longint          sa_i, sb_i, s_i;
        ua   = ma;
        ub   = mb;
        ci   = msub ? 0 : mcin;
        sa_i = $signed(ma);
        sb_i = $signed(mb);
        if (msub) begin
            t    = ua - ub;
            r.c  = (ua >= ub);
            s_i  = sa_i - sb_i;
        end else begin
            t    = ua + ub + ci;
            r.c  = ((t >> WIDTH) != 0);
            s_i  = sa_i + sb_i + longint'(ci);
        end
        r.sum = t[WIDTH-1:0];
        r.v   = (s_i > MAX_S) || (s_i < MIN_S);
        return r;
    endfunction

    // Monitor: queue expectations on accept, compare on every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub, carry_in));
                n_acc++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_without_accept", 32'(out_valid), 32'd0);
                end else begin
                    check("mon_sum", 32'(sum), 32'(exp_q[0].sum));
                    check("mon_carry_out", 32'(carry_out), 32'(exp_q[0].c));
                    check("mon_overflow", 32'(overflow), 32'(exp_q[0].v));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One directed operation with hand-computed expectations.
    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic os, input logic oc,
                         input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        int   cnt;
        res_t m;
        m = model(oa, ob, os, oc);
        check("model_sum", 32'(m.sum), 32'(es));
        check("model_carry", 32'(m.c), 32'(ec));
        check("model_ovf", 32'(m.v), 32'(ev));
        @(posedge clk); #1;
        a = oa; b = ob; sub = os; carry_in = oc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands need only be stable on the accept edge.
        a = WIDTH'($urandom); b = WIDTH'($urandom); carry_in = ~oc;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            check("in_ready_low_while_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(NIBBLES));
        check("dir_sum", 32'(sum), 32'(es));
        check("dir_carry_out", 32'(carry_out), 32'(ec));
        check("dir_overflow", 32'(overflow), 32'(ev));
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("out_valid_low_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_high_after_hs", 32'(in_ready), 32'd1);
    endtask

    logic [WIDTH-1:0] held;
    int               cnt;
    int               cyc;
    int               base;

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom % 6)
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state.
        #2;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #20 rst_n = 1'b1;

        // Directed vectors.
        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);

        // Backpressure: result held, in_valid pulses ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h0234; sub = 1'b1; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bp_latency", 32'(cnt), 32'(NIBBLES));
        check("bp_sum", 32'(sum), 32'h1000);
        held = sum;
        for (int i = 0; i < 10; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
            in_valid = ((i % 2) == 0);
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum_stable", 32'(sum), 32'(held));
            check("bp_carry_stable", 32'(carry_out), 32'd1);
            check("bp_ovf_stable", 32'(overflow), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'(out_valid), 32'd0);
        do_op(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Asynchronous reset during the second RUN cycle.
        @(posedge clk); #1;
        a = 16'hABCD; b = 16'h1234; sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_carry_out", 32'(carry_out), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("arst_no_out_valid", 32'(out_valid), 32'd0);
        end
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // Randomized operations with random output stalls.
        base = n_acc;
        cyc = 0;
        while ((n_acc - base) < 1000 && cyc < 50000) begin
            @(posedge clk); #1;
            a = pick_operand(); b = pick_operand();
            sub = 1'($urandom); carry_in = 1'($urandom);
            in_valid = (($urandom % 3) != 0);
            out_ready = (($urandom % 4) != 0);
            cyc++;
        end
        check("random_accept_budget", 32'(cyc < 50000), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("random_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

- Sequential WIDTH-bit adder/subtractor built around a single 4-bit adder slice (a + b + cin → sum, cout).
- Captures a full operand pair through a valid/ready input handshake, then feeds the slice one nibble per cycle, LSB nibble first, with the carry held in a flop between cycles.
- Presents the assembled WIDTH-bit result with carry and signed overflow on a valid/ready output handshake.
- Feeds the nibble adder and consumes its sum and carry, trading latency for area in wide datapaths.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4. NIBBLES = WIDTH/4.

- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair and mode are valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A (two's complement or unsigned)
- b  input  WIDTH  operand B
- carry_in  input  1  carry into nibble 0 for add; ignored when sub=1
- sub  input  1  0: a+b+carry_in; 1: a−b, computed as a + ~b + 1
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- carry_out  output  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow)
- overflow  output  1  signed overflow of the operation
- busy  output  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE). busy = (state ≠ IDLE). out_valid = (state == DONE). All three are decoded from registered state.
- IDLE, on in_valid (accept edge):
  - Capture opA ← a, opB ← (sub ? ~b : b), carry ← (sub ? 1 : carry_in).
  - Record sa ← a[WIDTH−1] and sb ← opB[WIDTH−1].
  - Clear the nibble counter idx ← 0 and go to RUN.
- RUN, each cycle:
  - Slice inputs: opA[3:0], opB[3:0], carry.
  - Slice sum nibble is written into result bits [4·idx+3 : 4·idx]; carry ← slice cout.
  - opA and opB shift right by 4; idx increments.
  - On the cycle with idx = NIBBLES−1: also register carry_out ← slice cout, then go to DONE.
- Overflow:
  - Registered at the RUN→DONE transition as (sa == sb) && (result[WIDTH−1] ≠ sa), using the final nibble's sum bit.
  - Computed identically for add and sub; for sub, sb is taken from the inverted B.
- DONE:
  - sum, carry_out and overflow are held stable.
  - On out_ready go to IDLE. No acceptance in that same cycle, because in_ready is low in DONE.
- in_valid is ignored outside IDLE. Operand inputs need only be stable on the accept edge.
- sum, carry_out and overflow hold their last values while in IDLE. They are updated only by RUN.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk):
  - state = IDLE, idx = 0, carry = 0.
  - sum = 0, carry_out = 0, overflow = 0.
  - out_valid = 0, busy = 0, in_ready = 1.
- Latency: accept at edge T → out_valid high after edge T+NIBBLES. For WIDTH = 16 that is 4 cycles.
- Result remains valid until the edge where out_valid && out_ready; out_valid is low after that edge.
- Minimum period between accepts: NIBBLES+2 cycles (accept, NIBBLES RUN edges, DONE handshake edge back to IDLE).
- out_ready may be held high in advance: DONE lasts exactly one cycle.
- Unbounded backpressure is allowed: DONE holds indefinitely with stable outputs.
- Reset asserted in RUN or DONE: the operation is discarded, no out_valid is produced, and all outputs take their reset values.
- WIDTH = 4: RUN lasts exactly one cycle.

## Test plan
- WIDTH=16, add 0x1234 + 0x0FCD, carry_in=0 → sum=0x2201, carry_out=0, overflow=0; out_valid exactly 4 cycles after accept; in_ready low from accept until the cycle after the DONE handshake.
- Add 0xFFFF + 0x0001, carry_in=0 → sum=0x0000, carry_out=1, overflow=0. Add 0x00FF + 0x0000, carry_in=1 → sum=0x0100, carry_out=0 (carry rippling across the nibble boundary).
- Add 0x8000 + 0x8000 → sum=0x0000, carry_out=1, overflow=1. Sub 0x7FFF − 0xFFFF with carry_in=0 (must be ignored) → sum=0x8000, carry_out=0, overflow=1. Sub 0x0005 − 0x0003 → sum=0x0002, carry_out=1, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid with new operands → sum/flags stable, in_ready=0, new operands not captured. Then out_ready=1 for one cycle → IDLE, next accept produces the correct new result.
- Reset mid-operation: deassert rst_n asynchronously (between clock edges) during the 2nd RUN cycle → outputs immediately at reset values, out_valid never asserts. After release, a fresh 0x1111 + 0x2222 → 0x3333.
- Randomised check: ≥1000 random a, b, sub, carry_in with random out_ready stalls. Compare each result against a WIDTH+1-bit reference (add: a+b+carry_in; sub: a+~b+1) for sum, carry_out and overflow, and check that results are delivered in order.
